// File: rtl/blackbox_sweeper_if.sv
// rtl/blackbox_sweeper_if.sv - control, status and stimulus bundle for the blackbox sweeper
interface blackbox_sweeper_if;
    logic       start;
    logic [7:0] expected;
    logic       a;
    logic       o;
    logic       v;
    logic       l;
    logic       busy;
    logic       done;
    logic [7:0] truth_table;
    logic [3:0] mismatch_count;
    logic       mismatch;

    // Sweeper side: drives stimulus and status, receives control and the sampled unit output
    modport master (
        input  start,
        input  expected,
        input  a,
        output o,
        output v,
        output l,
        output busy,
        output done,
        output truth_table,
        output mismatch_count,
        output mismatch
    );

    // Environment side: issues start/expected, returns the unit output, observes results
    modport slave (
        output start,
        output expected,
        output a,
        input  o,
        input  v,
        input  l,
        input  busy,
        input  done,
        input  truth_table,
        input  mismatch_count,
        input  mismatch
    );
endinterface

// File: rtl/blackbox_sweeper.sv
// rtl/blackbox_sweeper.sv - sweeps all 8 {o,v,l} vectors, captures a, compares to expected
module blackbox_sweeper #(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    blackbox_sweeper_if.master   bus
);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_t;

    // Each vector starts in SETTLE unless there is nothing to wait for
    localparam logic [3:0] SETTLE_LOAD = 4'(SETTLE_CYCLES);
    localparam state_t     FIRST_STATE = (SETTLE_CYCLES == 0) ? SAMPLE : SETTLE;

    state_t     state;
    state_t     state_next;
    logic [2:0] index;
    logic [3:0] settle_cnt;
    logic [7:0] expected_q;
    logic [2:0] ovl_q;
    logic       busy_q;
    logic       done_q;
    logic [7:0] table_q;
    logic [3:0] mismatch_count_q;
    logic       mismatch_q;

    logic       accept;
    logic       last;
    logic       miss;
    logic [3:0] count_next;

    assign accept     = bus.start && (state == IDLE || state == DONE);
    assign last       = (index == 3'd7);
    assign miss       = (bus.a != expected_q[index]);
    assign count_next = mismatch_count_q + {3'b000, miss};

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_next = FIRST_STATE;
                end
            end
            SETTLE: begin
                if (settle_cnt <= 4'd1) begin
                    state_next = SAMPLE;
                end
            end
            SAMPLE: begin
                state_next = last ? DONE : FIRST_STATE;
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: stimulus index, settle timer, capture and compare
    always_ff @(posedge clk) begin
        if (reset) begin
            index            <= 3'd0;
            settle_cnt       <= 4'd0;
            expected_q       <= 8'h00;
            ovl_q            <= 3'b000;
            busy_q           <= 1'b0;
            done_q           <= 1'b0;
            table_q          <= 8'h00;
            mismatch_count_q <= 4'd0;
            mismatch_q       <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (accept) begin
                        expected_q       <= bus.expected;
                        table_q          <= 8'h00;
                        mismatch_count_q <= 4'd0;
                        mismatch_q       <= 1'b0;
                        done_q           <= 1'b0;
                        index            <= 3'd0;
                        ovl_q            <= 3'b000;
                        busy_q           <= 1'b1;
                        settle_cnt       <= SETTLE_LOAD;
                    end
                end
                SETTLE: begin
                    if (settle_cnt != 4'd0) begin
                        settle_cnt <= settle_cnt - 4'd1;
                    end
                end
                SAMPLE: begin
                    table_q[index]   <= bus.a;
                    mismatch_count_q <= count_next;
                    mismatch_q       <= (count_next != 4'd0);
                    if (last) begin
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        ovl_q  <= 3'b000;
                    end else begin
                        index      <= index + 3'd1;
                        ovl_q      <= index + 3'd1;
                        settle_cnt <= SETTLE_LOAD;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o              = ovl_q[2];
    assign bus.v              = ovl_q[1];
    assign bus.l              = ovl_q[0];
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.truth_table    = table_q;
    assign bus.mismatch_count = mismatch_count_q;
    assign bus.mismatch       = mismatch_q;
endmodule
